// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with hardwired x0, write-to-read bypass and a reset-time clear sweep.
// Latency: reads are combinational (0 cycles); writes land on the next rising edge, bypassed in the same cycle.
// Backpressure: none; upstream must hold issue while init_done is low.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ENTRIES  = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*WIDTH-1:0]  rd,
    output logic                     init_done
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // One extra bit so ENTRIES == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]   ENT_LIMIT = (ADDR_W+1)'(ENTRIES);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(ENTRIES - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [ENTRIES];

    logic              wr_legal;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;

    always_comb begin
        wr_legal = we && ({1'b0, wa} < ENT_LIMIT) && !((ZERO_REG != 0) && (wa == '0));
    end

    // Sweep and user write share the single array write port.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        if (!areset) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = cnt;
                mem_wd = '0;
            end else begin
                mem_we = wr_legal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST_IDX) begin
                        state     <= READY;
                        init_done <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= CLEAR;
                    cnt       <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [WIDTH-1:0]  data;

            assign addr = ra[g*ADDR_W +: ADDR_W];

            always_comb begin
                data = '0;
                if (state == READY && ({1'b0, addr} < ENT_LIMIT) &&
                    !((ZERO_REG != 0) && (addr == '0))) begin
                    if (wr_legal && (wa == addr)) begin
                        data = wd;
                    end else begin
                        data = mem[addr];
                    end
                end
            end

            assign rd[g*WIDTH +: WIDTH] = data;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream and are checked against an array model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        areset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0, ra1, ra2;
    logic [9:0]  ra_ab;
    logic [14:0] ra_c;
    logic [63:0] rd_a, rd_b;
    logic [95:0] rd_c;
    logic        done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ra_ab = {ra1, ra0};
    assign ra_c  = {ra2, ra1, ra0};

    regfile_mp #(.WIDTH(32), .ADDR_W(5), .ENTRIES(32), .NUM_RD(2), .ZERO_REG(1)) u_a (
        .clk(clk), .areset(areset), .we(we), .wa(wa), .wd(wd),
        .ra(ra_ab), .rd(rd_a), .init_done(done_a));

    regfile_mp #(.WIDTH(32), .ADDR_W(5), .ENTRIES(32), .NUM_RD(2), .ZERO_REG(0)) u_b (
        .clk(clk), .areset(areset), .we(we), .wa(wa), .wd(wd),
        .ra(ra_ab), .rd(rd_b), .init_done(done_b));

    regfile_mp #(.WIDTH(32), .ADDR_W(5), .ENTRIES(24), .NUM_RD(3), .ZERO_REG(1)) u_c (
        .clk(clk), .areset(areset), .we(we), .wa(wa), .wd(wd),
        .ra(ra_c), .rd(rd_c), .init_done(done_c));

    // Model: a ready flag, a count of clean edges since reset, and the register contents.
    int          ent [3] = '{32, 32, 24};
    bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
    int          nrd [3] = '{2, 2, 3};
    logic [31:0] mm  [3][32];
    bit          m_rdy [3];
    int          m_sw  [3];
    bit          m_valid = 1'b0;

    function automatic bit legal_w(int k);
        return we && (int'(wa) < ent[k]) && !(zr[k] && wa == 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        if (!m_rdy[k])              return 32'd0;
        if (int'(a) >= ent[k])      return 32'd0;
        if (zr[k] && a == 5'd0)     return 32'd0;
        if (legal_w(k) && wa == a)  return wd;
        return mm[k][a];
    endfunction

    function automatic logic [31:0] act_rd(int k, int p);
        case (k)
            0:       return rd_a[p*32 +: 32];
            1:       return rd_b[p*32 +: 32];
            default: return rd_c[p*32 +: 32];
        endcase
    endfunction

    function automatic logic act_done(int k);
        case (k)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic [4:0] port_addr(int p);
        case (p)
            0:       return ra0;
            1:       return ra1;
            default: return ra2;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (areset) begin
                m_rdy[k] <= 1'b0;
                m_sw[k]  <= 0;
            end else if (!m_rdy[k]) begin
                m_sw[k] <= m_sw[k] + 1;
                if (m_sw[k] + 1 == ent[k]) begin
                    m_rdy[k] <= 1'b1;
                    for (int j = 0; j < 32; j++) mm[k][j] <= 32'd0;
                end
            end else if (legal_w(k)) begin
                mm[k][wa] <= wd;
            end
        end
        if (areset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_done(k) !== m_rdy[k]) begin
                    errors++;
                    $display("FAIL cmp_done dut%0d got %0b want %0b t=%0t", k, act_done(k), m_rdy[k], $time);
                end
                for (int p = 0; p < nrd[k]; p++) begin
                    checks++;
                    if (act_rd(k, p) !== exp_rd(k, port_addr(p))) begin
                        errors++;
                        $display("FAIL cmp_rd dut%0d port%0d addr %0d got %h want %h t=%0t",
                                 k, p, port_addr(p), act_rd(k, p), exp_rd(k, port_addr(p)), $time);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input string nm);
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk(nm, {31'd0, done_a}, (e == 32) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; we = 1'b0; wa = '0; wd = '0;
        ra0 = 5'd5; ra1 = 5'd31; ra2 = 5'd1;
        repeat (3) tick();
        chk("reset_done", {31'd0, done_a}, 32'd0);
        chk("reset_rd0", rd_a[31:0], 32'd0);
        areset = 1'b0;
        sweep_check("sweep_done");

        for (int i = 1; i < 32; i++) begin
            ra0 = 5'(i); ra1 = 5'(32 - i); ra2 = 5'(i);
            tick();
            chk("post_sweep_zero", rd_a[31:0], 32'd0);
        end

        // Bypass then array read.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra0 = 5'd5; ra1 = 5'd0; ra2 = 5'd5;
        #1 chk("bypass_rd0", rd_a[31:0], 32'hDEADBEEF);
        tick(); we = 1'b0;
        #1 chk("held_rd0", rd_a[31:0], 32'hDEADBEEF);

        // x0 handling, hardwired vs ordinary register.
        tick(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra0 = 5'd0; ra1 = 5'd0;
        #1 chk("x0_byp_rd0", rd_a[31:0], 32'd0);
        chk("x0_byp_rd1", rd_a[63:32], 32'd0);
        chk("nz_byp_rd0", rd_b[31:0], 32'hFFFFFFFF);
        tick(); we = 1'b0;
        #1 chk("x0_held_rd0", rd_a[31:0], 32'd0);
        chk("nz_held_rd1", rd_b[63:32], 32'hFFFFFFFF);

        // Out-of-range write on the 24-entry configuration.
        tick(); we = 1'b1; wa = 5'd26; wd = 32'hCAFEF00D; ra0 = 5'd26; ra1 = 5'd26; ra2 = 5'd26;
        #1 chk("oor_byp_c", rd_c[31:0], 32'd0);
        chk("inrange_byp_a", rd_a[31:0], 32'hCAFEF00D);
        tick(); we = 1'b0;
        #1 chk("oor_held_c", rd_c[95:64], 32'd0);
        tick(); we = 1'b1; wa = 5'd23; wd = 32'hA5A5A5A5;
        tick(); we = 1'b0; ra0 = 5'd23; ra1 = 5'd23; ra2 = 5'd0;
        #1 chk("c_rd0", rd_c[31:0], 32'hA5A5A5A5);
        chk("c_rd1", rd_c[63:32], 32'hA5A5A5A5);
        chk("c_rd2", rd_c[95:64], 32'd0);

        // Reset while ready.
        tick(); we = 1'b1; wa = 5'd3; wd = 32'h55; ra0 = 5'd3; ra1 = 5'd5;
        tick(); we = 1'b0;
        #1 chk("x3_written", rd_a[31:0], 32'h55);
        areset = 1'b1;
        tick(); areset = 1'b0;
        chk("ready_rst_done", {31'd0, done_a}, 32'd0);
        chk("ready_rst_mask", rd_a[31:0], 32'd0);
        sweep_check("resweep_done");
        chk("x3_cleared", rd_a[31:0], 32'd0);
        chk("x5_cleared", rd_a[63:32], 32'd0);

        // Reset on sweep edge 10, with a write dropped during the sweep.
        areset = 1'b1;
        tick(); areset = 1'b0; ra0 = 5'd7; ra1 = 5'd7; ra2 = 5'd7;
        for (int e = 1; e <= 9; e++) begin
            we = (e == 5);
            wa = 5'd7; wd = 32'h1234;
            tick();
        end
        we = 1'b0;
        areset = 1'b1;
        tick(); areset = 1'b0;
        chk("mid_rst_done", {31'd0, done_a}, 32'd0);
        sweep_check("mid_sweep_done");
        chk("x7_dropped", rd_a[31:0], 32'd0);
        chk("x7_dropped_c", rd_c[63:32], 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
